// File: rtl/serial_cmd_receiver.sv
// Deserializes the framed command bit stream, checks even parity and delivers words to the arbiter.
// A per-frame inactivity watchdog drives the arbiter's active-low timeout input.
module serial_cmd_receiver #(
    parameter int CACHE_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   sys_clk,
    input  logic                   porb,
    input  logic                   csb,
    input  logic                   bit_stb,
    input  logic                   sdi,
    output logic [CACHE_WIDTH-1:0] rx_data,
    output logic                   valid,
    output logic                   timeoutb,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   busy
);

    // state    | meaning
    // IDLE     | waiting for csb low
    // SHIFT    | collecting data bits, MSB first
    // PARITY   | waiting for the parity bit
    // WAIT_END | word done, ignoring strobes until csb rises
    // TIMEOUT  | strobe inactivity expired, timeoutb held low until csb rises
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        WAIT_END,
        TIMEOUT
    } state_t;

    localparam int BW = $clog2(CACHE_WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(CACHE_WIDTH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [CACHE_WIDTH-1:0] shreg;
    logic [BW-1:0]          bit_cnt;
    logic [TW-1:0]          tmo_cnt;

    always_ff @(posedge sys_clk or negedge porb) begin
        if (!porb) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            rx_data    <= '0;
            valid      <= 1'b0;
            timeoutb   <= 1'b1;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!csb) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        shreg   <= '0;
                        tmo_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // csb has priority over a coincident strobe
                    if (csb) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (bit_stb) begin
                        shreg   <= {shreg[CACHE_WIDTH-2:0], sdi};
                        bit_cnt <= bit_cnt + BW'(1);
                        tmo_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= PARITY;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= TIMEOUT;
                        timeoutb <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                PARITY: begin
                    if (csb) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (bit_stb) begin
                        state   <= WAIT_END;
                        tmo_cnt <= '0;
                        if (^{shreg, sdi}) begin
                            parity_err <= 1'b1;
                        end else begin
                            rx_data <= shreg;
                            valid   <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= TIMEOUT;
                        timeoutb <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                WAIT_END: begin
                    if (csb) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                TIMEOUT: begin
                    if (csb) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        timeoutb <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    timeoutb <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmd_receiver.sv
// Directed bench for serial_cmd_receiver: frame vector table plus abort, timeout and reset sequences.
module tb_serial_cmd_receiver;

    localparam int W   = 16;
    localparam int TMO = 16;

    logic         sys_clk = 1'b0;
    logic         porb;
    logic         csb;
    logic         bit_stb;
    logic         sdi;
    logic [W-1:0] rx_data;
    logic         valid;
    logic         timeoutb;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    int n_total = 0;
    int n_pass  = 0;
    int cnt_valid = 0;
    int cnt_perr  = 0;
    int cnt_ferr  = 0;

    serial_cmd_receiver #(.CACHE_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk    (sys_clk),
        .porb       (porb),
        .csb        (csb),
        .bit_stb    (bit_stb),
        .sdi        (sdi),
        .rx_data    (rx_data),
        .valid      (valid),
        .timeoutb   (timeoutb),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (valid === 1'b1) cnt_valid++;
        if (parity_err === 1'b1) cnt_perr++;
        if (frame_err === 1'b1) cnt_ferr++;
    end

    typedef struct {
        logic [W-1:0] data;
        logic         par;
        int           spacing;
        logic         good;
        logic [W-1:0] rx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int spacing);
        bit_stb = 1'b1;
        sdi     = b;
        tick();
        bit_stb = 1'b0;
        for (int k = 1; k < spacing; k++) tick();
    endtask

    task automatic start_frame();
        csb = 1'b0;
        tick();
    endtask

    task automatic run_frame(input logic [W-1:0] data, input logic par, input int spacing,
                             input logic good, input logic [W-1:0] exp_rx);
        int v0, p0, f0;
        v0 = cnt_valid; p0 = cnt_perr; f0 = cnt_ferr;
        start_frame();
        check("busy_at_start", 32'(busy), 32'd1);
        for (int i = W - 1; i >= 0; i--) send_bit(data[i], spacing);
        bit_stb = 1'b1;
        sdi     = par;
        tick();
        check("valid_after_parity", 32'(valid), 32'(good));
        check("perr_after_parity", 32'(parity_err), 32'(!good));
        check("rx_after_parity", 32'(rx_data), 32'(exp_rx));
        sdi = ~par;
        tick();
        bit_stb = 1'b0;
        check("valid_one_cycle", 32'(valid), 32'd0);
        check("perr_one_cycle", 32'(parity_err), 32'd0);
        check("rx_after_extra_bit", 32'(rx_data), 32'(exp_rx));
        csb = 1'b1;
        tick();
        check("busy_after_csb_rise", 32'(busy), 32'd0);
        check("valid_pulse_count", 32'(cnt_valid - v0), 32'(good));
        check("perr_pulse_count", 32'(cnt_perr - p0), 32'(!good));
        check("ferr_pulse_count", 32'(cnt_ferr - f0), 32'd0);
    endtask

    initial begin
        vecs[0] = '{data: 16'hA5C3, par: 1'b0, spacing: 3, good: 1'b1, rx: 16'hA5C3};
        vecs[1] = '{data: 16'hA5C3, par: 1'b1, spacing: 3, good: 1'b0, rx: 16'hA5C3};
        vecs[2] = '{data: 16'h00FF, par: 1'b0, spacing: 1, good: 1'b1, rx: 16'h00FF};
        vecs[3] = '{data: 16'hFFFE, par: 1'b1, spacing: 1, good: 1'b1, rx: 16'hFFFE};
        vecs[4] = '{data: 16'h0000, par: 1'b0, spacing: 2, good: 1'b1, rx: 16'h0000};
        vecs[5] = '{data: 16'h8001, par: 1'b1, spacing: 2, good: 1'b0, rx: 16'h0000};
        vecs[6] = '{data: 16'hFFFF, par: 1'b0, spacing: 1, good: 1'b1, rx: 16'hFFFF};
        vecs[7] = '{data: 16'h1234, par: 1'b1, spacing: 2, good: 1'b1, rx: 16'h1234};

        porb = 1'b0; csb = 1'b1; bit_stb = 1'b0; sdi = 1'b0;
        repeat (3) tick();
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeoutb", 32'(timeoutb), 32'd1);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        porb = 1'b1;
        tick();

        // consecutive entries 2 and 3 run back-to-back with a one-cycle csb gap
        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].data, vecs[v].par, vecs[v].spacing, vecs[v].good, vecs[v].rx);
        end

        // early abort after 5 bits
        start_frame();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 2);
        csb = 1'b1;
        tick();
        check("abort_frame_err", 32'(frame_err), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        tick();
        check("abort_ferr_one_cycle", 32'(frame_err), 32'd0);

        // abort coinciding with the 6th strobe
        start_frame();
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1);
        csb = 1'b1; bit_stb = 1'b1; sdi = 1'b1;
        tick();
        bit_stb = 1'b0;
        check("abort_stb_frame_err", 32'(frame_err), 32'd1);
        check("abort_stb_busy", 32'(busy), 32'd0);
        check("abort_stb_valid", 32'(valid), 32'd0);
        tick();
        run_frame(16'hA5C3, 1'b0, 1, 1'b1, 16'hA5C3);

        // timeout after 3 bits
        start_frame();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        for (int i = 1; i < TMO; i++) tick();
        check("tmo_before_expiry", 32'(timeoutb), 32'd1);
        tick();
        check("tmo_at_expiry", 32'(timeoutb), 32'd0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        repeat (3) tick();
        check("tmo_held", 32'(timeoutb), 32'd0);
        check("tmo_busy", 32'(busy), 32'd1);
        csb = 1'b1;
        tick();
        check("tmo_release", 32'(timeoutb), 32'd1);
        check("tmo_release_busy", 32'(busy), 32'd0);
        check("tmo_no_valid", 32'(valid), 32'd0);
        tick();

        // timeout with no strobe after frame start
        start_frame();
        for (int i = 1; i < TMO; i++) tick();
        check("tmo_nostb_before", 32'(timeoutb), 32'd1);
        tick();
        check("tmo_nostb_expiry", 32'(timeoutb), 32'd0);
        csb = 1'b1;
        tick();
        check("tmo_nostb_release", 32'(timeoutb), 32'd1);

        // strobe exactly on the 16th edge prevents the timeout
        start_frame();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        for (int i = 1; i < TMO; i++) tick();
        send_bit(1'b0, 1);
        check("tmo_prevented", 32'(timeoutb), 32'd1);
        for (int i = 1; i < TMO; i++) tick();
        check("tmo_prevented_later", 32'(timeoutb), 32'd1);
        csb = 1'b1;
        tick();
        check("tmo_prevented_abort", 32'(frame_err), 32'd1);
        tick();

        // reset mid-frame after 8 bits
        start_frame();
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1);
        porb = 1'b0;
        #2;
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_timeoutb", 32'(timeoutb), 32'd1);
        check("midrst_valid", 32'(valid), 32'd0);
        tick();
        porb = 1'b1;
        csb  = 1'b1;
        tick();
        run_frame(16'h1234, 1'b1, 2, 1'b1, 16'h1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
